// File: rtl/roulette_wheel_if.sv
// Roulette number interface: spin request / result handshake plus wheel display.
// Optional force-result signals appear when ROULETTE_FORCE_RESULT_EN is defined.
interface roulette_wheel_if;
    logic       spin_req;
    logic       result_ack;
    logic [4:0] randnum;
    logic       result_valid;
    logic       busy;
    logic [4:0] wheel_pos;
`ifdef ROULETTE_FORCE_RESULT_EN
    logic       force_en;
    logic [4:0] force_value;

    // Producer side (the wheel)
    modport master (
        input  spin_req, result_ack, force_en, force_value,
        output randnum, result_valid, busy, wheel_pos
    );

    // Consumer side (game logic)
    modport slave (
        output spin_req, result_ack, force_en, force_value,
        input  randnum, result_valid, busy, wheel_pos
    );
`else
    // Producer side (the wheel)
    modport master (
        input  spin_req, result_ack,
        output randnum, result_valid, busy, wheel_pos
    );

    // Consumer side (game logic)
    modport slave (
        output spin_req, result_ack,
        input  randnum, result_valid, busy, wheel_pos
    );
`endif
endinterface

// File: rtl/roulette_wheel.sv
// Roulette wheel: free-running 5-bit LFSR captured on a spin request, a linearly
// decelerating wheel animation that lands on the captured number, and a
// valid/ack handshake holding the result for the game logic.
// Optional macro ROULETTE_FORCE_RESULT_EN adds force_en/force_value to override
// the captured number (0 clamps to 1); animation and timing are unchanged.
module roulette_wheel #(
    parameter int unsigned SPIN_STEPS = 16,
    parameter int unsigned STEP_BASE  = 1000000,
    parameter int unsigned STEP_INC   = 250000
) (
    input  logic             Clock,
    input  logic             reset_n,
    roulette_wheel_if.master rw
);

    // Longest step length; the cycle counter only ever reaches CYC_MAX-1
    localparam int unsigned CYC_MAX   = STEP_BASE + (SPIN_STEPS - 1) * STEP_INC;
    localparam int unsigned CYC_W     = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
    localparam int unsigned STEP_W    = 8;
    localparam int unsigned START_OFS = SPIN_STEPS % 31;
    // Start position is ((t-1-ofs+31) mod 31)+1; t+30-ofs folds the constants together
    localparam logic [5:0]        START_BIAS = 6'(30 - START_OFS);
    localparam logic [CYC_W-1:0]  LIMIT0     = CYC_W'(STEP_BASE - 1);
    localparam logic [CYC_W-1:0]  LIMIT_INC  = CYC_W'(STEP_INC);
    localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(SPIN_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SPIN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [4:0]          lfsr_q, lfsr_d;
    logic                spin_req_q, spin_req_d;
    logic [4:0]          target_q, target_d;
    logic [4:0]          randnum_q, randnum_d;
    logic                result_valid_q, result_valid_d;
    logic                busy_q, busy_d;
    logic [4:0]          wheel_pos_q, wheel_pos_d;
    logic [CYC_W-1:0]    cycle_q, cycle_d;
    logic [CYC_W-1:0]    limit_q, limit_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                rise_c;
    logic [4:0]          pick_c;

    // Position the wheel starts from so that SPIN_STEPS advances land on t
    function automatic logic [4:0] start_pos(input logic [4:0] t);
        logic [5:0] s;
        s = {1'b0, t} + START_BIAS;
        if (s >= 6'd31) begin
            s = s - 6'd31;
        end
        return 5'(s) + 5'd1;
    endfunction

    // One wheel advance, 31 wraps to 1
    function automatic logic [4:0] next_pos(input logic [4:0] p);
        return (p == 5'd31) ? 5'd1 : p + 5'd1;
    endfunction

    // Value captured as the spin target
`ifdef ROULETTE_FORCE_RESULT_EN
    always_comb begin
        pick_c = lfsr_q;
        if (rw.force_en) begin
            pick_c = (rw.force_value == 5'd0) ? 5'd1 : rw.force_value;
        end
    end
`else
    always_comb begin
        pick_c = lfsr_q;
    end
`endif

    // Next-state and output logic
    always_comb begin
        state_d        = state_q;
        lfsr_d         = (lfsr_q == 5'd0) ? 5'd1 : {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
        spin_req_d     = rw.spin_req;
        target_d       = target_q;
        randnum_d      = randnum_q;
        result_valid_d = result_valid_q;
        busy_d         = busy_q;
        wheel_pos_d    = wheel_pos_q;
        cycle_d        = cycle_q;
        limit_d        = limit_q;
        step_d         = step_q;
        rise_c         = rw.spin_req & ~spin_req_q;

        case (state_q)
            IDLE: begin
                busy_d         = 1'b0;
                result_valid_d = 1'b0;
                if (rise_c) begin
                    target_d    = pick_c;
                    wheel_pos_d = start_pos(pick_c);
                    step_d      = '0;
                    cycle_d     = '0;
                    limit_d     = LIMIT0;
                    busy_d      = 1'b1;
                    state_d     = SPIN;
                end
            end
            SPIN: begin
                if (cycle_q == limit_q) begin
                    wheel_pos_d = next_pos(wheel_pos_q);
                    cycle_d     = '0;
                    step_d      = step_q + STEP_W'(1);
                    if (step_q == STEP_LAST) begin
                        randnum_d      = target_q;
                        result_valid_d = 1'b1;
                        busy_d         = 1'b0;
                        state_d        = DONE;
                    end else begin
                        limit_d = limit_q + LIMIT_INC;
                    end
                end else begin
                    cycle_d = cycle_q + CYC_W'(1);
                end
            end
            DONE: begin
                if (rw.result_ack) begin
                    result_valid_d = 1'b0;
                    state_d        = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            lfsr_q         <= 5'd1;
            spin_req_q     <= 1'b0;
            target_q       <= 5'd0;
            randnum_q      <= 5'd0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            wheel_pos_q    <= 5'd1;
            cycle_q        <= '0;
            limit_q        <= '0;
            step_q         <= '0;
        end else begin
            state_q        <= state_d;
            lfsr_q         <= lfsr_d;
            spin_req_q     <= spin_req_d;
            target_q       <= target_d;
            randnum_q      <= randnum_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
            wheel_pos_q    <= wheel_pos_d;
            cycle_q        <= cycle_d;
            limit_q        <= limit_d;
            step_q         <= step_d;
        end
    end

    assign rw.randnum      = randnum_q;
    assign rw.result_valid = result_valid_q;
    assign rw.busy         = busy_q;
    assign rw.wheel_pos    = wheel_pos_q;

endmodule
